// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//   Raster timing generator for the video output path. A clock divider
//   produces a pixel-advance strobe. That strobe drives a horizontal position
//   counter and a vertical position counter. Each counter has a four-phase
//   FSM (VIS / FP / SYNC / BP). Sync and blank are registered from the
//   next-state values, so they change on the same edge as col/row and always
//   describe the coordinate currently shown on col/row.
//
//   Defaults give 640x480 @ 60 Hz from a 50 MHz clock (CLK_DIV = 2).
//
// Optional build macro:
//   VGA_TIMING_IRQ_EN - adds irq/irq_ack. irq is a vblank-start interrupt.
//                       It is set on the edge where the vertical FSM enters
//                       FP and cleared by an acknowledge. If set and ack
//                       happen together, set wins.
//
// Ports:
//   clock        system clock
//   reset_l      asynchronous active-low reset
//   enable       run/hold; when low all timing state freezes
//   pix_en       combinational one-clock strobe per pixel advance
//   col, row     current raster coordinate
//   hsync_l      horizontal sync, active low (registered)
//   vsync_l      vertical sync, active low (registered)
//   blank        high outside the visible region (registered)
//   line_start   one-clock pulse on the first clock with col==0 after a wrap
//   frame_start  one-clock pulse on the first clock with (0,0) after a wrap
//   irq_ack, irq (VGA_TIMING_IRQ_EN only) vblank interrupt handshake
// -----------------------------------------------------------------------------
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int COL_W    = $clog2(H_TOTAL),
  localparam int ROW_W    = $clog2(V_TOTAL)
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             enable,
  output logic             pix_en,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             hsync_l,
  output logic             vsync_l,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_IRQ_EN
  ,
  input  logic             irq_ack,
  output logic             irq
`endif
);

  // A width of 1 is kept for CLK_DIV==1. In that case div_cnt stays at 0
  // and pix_en follows enable.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Last coordinate of each phase. The FSM leaves a phase on the pixel
  // advance that occurs while sitting on that coordinate.
  localparam logic [COL_W-1:0] H_VIS_END  = COL_W'(H_VISIBLE - 1);
  localparam logic [COL_W-1:0] H_FP_END   = COL_W'(H_VISIBLE + H_FP - 1);
  localparam logic [COL_W-1:0] H_SYNC_END = COL_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [COL_W-1:0] H_LAST     = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_VIS_END  = ROW_W'(V_VISIBLE - 1);
  localparam logic [ROW_W-1:0] V_FP_END   = ROW_W'(V_VISIBLE + V_FP - 1);
  localparam logic [ROW_W-1:0] V_SYNC_END = ROW_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [ROW_W-1:0] V_LAST     = ROW_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    VIS  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_t;

  phase_t           h_state, h_nxt;
  phase_t           v_state, v_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             col_last;
  logic             row_last;
  logic             line_wrap;

  // ---------------------------------------------------------------------------
  // Divider strobe and wrap detection
  // ---------------------------------------------------------------------------
  assign pix_en    = (div_cnt == DIV_LAST) && enable;
  assign col_last  = (col == H_LAST);
  assign row_last  = (row == V_LAST);
  // The vertical machinery advances only on the last pixel of a line.
  assign line_wrap = pix_en && col_last;

  // ---------------------------------------------------------------------------
  // Next-phase logic. The registered sync/blank outputs are derived from these
  // values, so they line up with the col/row that is loaded on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    h_nxt = h_state;
    if (pix_en) begin
      unique case (h_state)
        VIS:  if (col == H_VIS_END)  h_nxt = FP;
        FP:   if (col == H_FP_END)   h_nxt = SYNC;
        SYNC: if (col == H_SYNC_END) h_nxt = BP;
        BP:   if (col == H_LAST)     h_nxt = VIS;
      endcase
    end
  end

  always_comb begin
    v_nxt = v_state;
    if (line_wrap) begin
      unique case (v_state)
        VIS:  if (row == V_VIS_END)  v_nxt = FP;
        FP:   if (row == V_FP_END)   v_nxt = SYNC;
        SYNC: if (row == V_SYNC_END) v_nxt = BP;
        BP:   if (row == V_LAST)     v_nxt = VIS;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      div_cnt     <= '0;
      col         <= '0;
      row         <= '0;
      h_state     <= VIS;
      v_state     <= VIS;
      hsync_l     <= 1'b1;
      vsync_l     <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (enable)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

      if (pix_en)
        col <= col_last ? '0 : col + COL_W'(1);

      if (line_wrap)
        row <= row_last ? '0 : row + ROW_W'(1);

      h_state <= h_nxt;
      v_state <= v_nxt;
      hsync_l <= (h_nxt != SYNC);
      vsync_l <= (v_nxt != SYNC);
      blank   <= (h_nxt != VIS) || (v_nxt != VIS);

      // Pulses come only from an actual wrap. They never come from reset
      // release, and a held enable produces no wrap.
      line_start  <= line_wrap;
      frame_start <= line_wrap && row_last;
    end
  end

`ifdef VGA_TIMING_IRQ_EN
  // ---------------------------------------------------------------------------
  // Vblank interrupt: the set condition is checked first, so a coincident ack
  // cannot swallow a new vblank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l)
      irq <= 1'b0;
    else if ((v_state != FP) && (v_nxt == FP))
      irq <= 1'b1;
    else if (irq_ack)
      irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//   Self-checking bench for vga_timing. It uses reduced raster dimensions so
//   that several complete frames fit in a short run. The reference model
//   keeps a single count of enabled clocks and derives the pixel index, col,
//   row, sync, blank and pulses from it with plain division and range tests.
// -----------------------------------------------------------------------------
module tb_vga_timing;

  localparam int D   = 2;
  localparam int HV  = 16;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 4;
  localparam int VV  = 6;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int COL_W = $clog2(HT);
  localparam int ROW_W = $clog2(VT);
  localparam int FRAME_CLKS = HT * VT * D;

  logic             clock = 1'b0;
  logic             reset_l = 1'b0;
  logic             enable = 1'b0;
  logic             pix_en;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             hsync_l, vsync_l, blank, line_start, frame_start;
`ifdef VGA_TIMING_IRQ_EN
  logic             irq_ack = 1'b0;
  logic             irq;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  int n        = 0;   // enabled clocks since reset
  bit prev_adv = 1'b0; // previous edge advanced the pixel position
  bit irq_m    = 1'b0;

  always #5 clock = ~clock;

  vga_timing #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clock(clock),
    .reset_l(reset_l),
    .enable(enable),
    .pix_en(pix_en),
    .col(col),
    .row(row),
    .hsync_l(hsync_l),
    .vsync_l(vsync_l),
    .blank(blank),
    .line_start(line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_IRQ_EN
    ,
    .irq_ack(irq_ack),
    .irq(irq)
`endif
  );

  // ---------------------------------------------------------------------------
  // Model views
  // ---------------------------------------------------------------------------
  function automatic int m_col();
    return (n / D) % HT;
  endfunction

  function automatic int m_row();
    return ((n / D) / HT) % VT;
  endfunction

  function automatic bit m_hsync_l();
    int c = m_col();
    return !(c >= HV + HFP && c < HV + HFP + HS);
  endfunction

  function automatic bit m_vsync_l();
    int r = m_row();
    return !(r >= VV + VFP && r < VV + VFP + VS);
  endfunction

  function automatic bit m_blank();
    return (m_col() >= HV) || (m_row() >= VV);
  endfunction

  function automatic bit m_pix_en();
    return enable && ((n % D) == D - 1);
  endfunction

  function automatic bit m_ls();
    return prev_adv && (m_col() == 0);
  endfunction

  function automatic bit m_fs();
    return prev_adv && (m_col() == 0) && (m_row() == 0);
  endfunction

  // One clock: drive inputs, take the edge, advance the model, then settle.
  task automatic step(input bit en, input bit ack);
    bit adv;
    enable = en;
`ifdef VGA_TIMING_IRQ_EN
    irq_ack = ack;
`endif
    @(posedge clock);
    adv = en && ((n % D) == D - 1);
    if (en) n++;
    prev_adv = adv;
    if (adv && m_col() == 0 && m_row() == VV) irq_m = 1'b1;
    else if (ack) irq_m = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    enable = 1'b0;
    reset_l = 1'b0;
    @(negedge clock);
    reset_l = 1'b1;
    n = 0;
    prev_adv = 1'b0;
    irq_m = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Values while held in reset
    @(posedge clock); #1;
    tests++; if (col !== '0 || row !== '0) begin fails++;
      $display("FAIL reset_pos col=%0d row=%0d want 0,0", col, row); end
    tests++; if (hsync_l !== 1'b1 || vsync_l !== 1'b1 || blank !== 1'b0) begin fails++;
      $display("FAIL reset_sync hs=%b vs=%b bl=%b want 1,1,0", hsync_l, vsync_l, blank); end
    tests++; if (pix_en !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) begin fails++;
      $display("FAIL reset_pulses pe=%b ls=%b fs=%b want 0,0,0", pix_en, line_start, frame_start); end
    @(negedge clock);
    reset_l = 1'b1;

    // Go mid-frame, then pull reset between clock edges
    for (int i = 0; i < 200 + int'($urandom_range(0, 200)); i++) step(1'b1, 1'b0);
    tests++; if (int'(row) !== m_row() || int'(col) !== m_col()) begin fails++;
      $display("FAIL pre_reset_pos col=%0d row=%0d want %0d,%0d", col, row, m_col(), m_row()); end
    #2 reset_l = 1'b0;
    #1;
    tests++; if (col !== '0 || row !== '0) begin fails++;
      $display("FAIL async_reset_pos col=%0d row=%0d want 0,0", col, row); end
    tests++; if (hsync_l !== 1'b1 || vsync_l !== 1'b1 || blank !== 1'b0) begin fails++;
      $display("FAIL async_reset_sync hs=%b vs=%b bl=%b want 1,1,0", hsync_l, vsync_l, blank); end
    n = 0; prev_adv = 1'b0; irq_m = 1'b0;
    @(negedge clock);
    reset_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      tests++; if (frame_start !== 1'b0 || line_start !== 1'b0) begin fails++;
        $display("FAIL release_pulse cyc=%0d fs=%b ls=%b want 0,0", i, frame_start, line_start); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_divider();
    apply_reset();
    for (int i = 1; i <= D * (HV - 1); i++) begin
      step(1'b1, 1'b0);
      tests++; if (pix_en !== ((i % D) == D - 1)) begin fails++;
        $display("FAIL div_pix_en clk=%0d got=%b want=%b", i, pix_en, (i % D) == D - 1); end
      if (i == D) begin
        tests++; if (col !== COL_W'(1)) begin fails++;
          $display("FAIL div_col_first got=%0d want=1", col); end
      end
    end
    tests++; if (int'(col) !== HV - 1) begin fails++;
      $display("FAIL div_col_last_visible got=%0d want=%0d", col, HV - 1); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hold();
    int  target = HV + HFP - 1;
    bit  found = 1'b0;
    apply_reset();
    for (int i = 0; i < 4 * HT * D && !found; i++) begin
      step(1'b1, 1'b0);
      if (m_col() == target && (n % D) == 0) found = 1'b1;
    end
    tests++; if (!found || int'(col) !== target || hsync_l !== 1'b1) begin fails++;
      $display("FAIL hold_reach found=%b col=%0d hs=%b want col=%0d hs=1", found, col, hsync_l, target); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      tests++; if (int'(col) !== target || hsync_l !== 1'b1 || pix_en !== 1'b0) begin fails++;
        $display("FAIL hold_freeze cyc=%0d col=%0d hs=%b pe=%b want %0d,1,0", i, col, hsync_l, pix_en, target); end
    end
    step(1'b1, 1'b0);
    tests++; if (hsync_l !== 1'b1 || int'(col) !== target) begin fails++;
      $display("FAIL hold_resume1 hs=%b col=%0d want 1,%0d", hsync_l, col, target); end
    step(1'b1, 1'b0);
    tests++; if (hsync_l !== 1'b0 || int'(col) !== target + 1) begin fails++;
      $display("FAIL hold_resume2 hs=%b col=%0d want 0,%0d", hsync_l, col, target + 1); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_frame_length();
    int clks = 0;
    bit seen = 1'b0;
    apply_reset();
    while (!seen && clks < 2 * FRAME_CLKS) begin
      step(1'b1, 1'b0);
      clks++;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen || clks !== FRAME_CLKS) begin fails++;
      $display("FAIL frame_length seen=%b clks=%0d want %0d", seen, clks, FRAME_CLKS); end
    tests++; if (line_start !== 1'b1 || col !== '0 || row !== '0) begin fails++;
      $display("FAIL frame_wrap ls=%b col=%0d row=%0d want 1,0,0", line_start, col, row); end
    step(1'b1, 1'b0);
    tests++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin fails++;
      $display("FAIL frame_pulse_width ls=%b fs=%b want 0,0", line_start, frame_start); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random_run();
    apply_reset();
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      tests++; if (int'(col) !== m_col() || int'(row) !== m_row()) begin fails++;
        $display("FAIL rnd_pos cyc=%0d col=%0d row=%0d want %0d,%0d", i, col, row, m_col(), m_row()); end
      tests++; if (hsync_l !== m_hsync_l() || vsync_l !== m_vsync_l() || blank !== m_blank()) begin fails++;
        $display("FAIL rnd_sync cyc=%0d hs=%b vs=%b bl=%b want %b,%b,%b", i, hsync_l, vsync_l, blank,
                 m_hsync_l(), m_vsync_l(), m_blank()); end
      tests++; if (pix_en !== m_pix_en() || line_start !== m_ls() || frame_start !== m_fs()) begin fails++;
        $display("FAIL rnd_pulse cyc=%0d pe=%b ls=%b fs=%b want %b,%b,%b", i, pix_en, line_start, frame_start,
                 m_pix_en(), m_ls(), m_fs()); end
`ifdef VGA_TIMING_IRQ_EN
      tests++; if (irq !== irq_m) begin fails++;
        $display("FAIL rnd_irq cyc=%0d got=%b want=%b", i, irq, irq_m); end
`endif
    end
  endtask

`ifdef VGA_TIMING_IRQ_EN
  // ---------------------------------------------------------------------------
  task automatic test_irq();
    int clks;
    apply_reset();
    clks = 0;
    while (!irq_m && clks < 2 * FRAME_CLKS) begin step(1'b1, 1'b0); clks++; end
    tests++; if (irq !== 1'b1 || int'(row) !== VV || col !== '0) begin fails++;
      $display("FAIL irq_set irq=%b row=%0d col=%0d want 1,%0d,0", irq, row, col, VV); end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    tests++; if (irq !== 1'b1) begin fails++;
      $display("FAIL irq_sticky got=%b want=1", irq); end
    step(1'b1, 1'b1);
    tests++; if (irq !== 1'b0) begin fails++;
      $display("FAIL irq_ack_clear got=%b want=0", irq); end
    // Hold ack through the next vblank start: set must win
    clks = 0;
    while (!irq_m && clks < 2 * FRAME_CLKS) begin step(1'b1, 1'b1); clks++; end
    tests++; if (irq !== 1'b1 || int'(row) !== VV) begin fails++;
      $display("FAIL irq_set_wins irq=%b row=%0d want 1,%0d", irq, row, VV); end
    step(1'b1, 1'b1);
    tests++; if (irq !== 1'b0) begin fails++;
      $display("FAIL irq_ack_after_set got=%b want=0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_divider();
    test_hold();
    test_frame_length();
    test_random_run();
`ifdef VGA_TIMING_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
